// File: rtl/if_fsm_pkg.sv
// if_fsm_pkg: shared state encodings, opcode constants and bus width for the fetch FSM
package if_fsm_pkg;
  localparam int BUS_W = 16;
  typedef enum logic [3:0] {
    S_IDLE, S_PC_OUT, S_MEM_REQ, S_IR_LOAD, S_DECODE, S_EXEC, S_SKIP, S_HALT, S_FAULT
  } state_t;
  localparam logic [3:0] OP_LEGAL_LO = 4'b0001;
  localparam logic [3:0] OP_LEGAL_HI = 4'b1000;
  localparam logic [3:0] OP_HALT     = 4'b1111;
  function automatic logic op_legal(input logic [3:0] op);
    return op >= OP_LEGAL_LO && op <= OP_LEGAL_HI;
  endfunction
endpackage

// File: rtl/if_watchdog.sv
// if_watchdog: counts EXEC cycles; o_last flags the final cycle allowed before a fault
module if_watchdog #(
  parameter int TIMEOUT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_last
);
  localparam int W = $clog2(TIMEOUT) + 1;
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + W'(1);
  end
  assign o_last = r_cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/if_fsm.sv
// if_fsm: instruction fetch/decode sequencer with illegal-opcode skip, HALT and exec watchdog
module if_fsm
  import if_fsm_pkg::*;
#(
  parameter int EXEC_TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BUS_W-1:0] bus_in,
  input  logic             mem_ready,
  input  logic             exec_done,
  output logic             pcOutEN,
  output logic             marLatch,
  output logic             memRead,
  output logic             mdrOutEN,
  output logic             IF_active,
  output logic [BUS_W-1:0] instruction,
  output logic             pcInc,
  output logic             illegal,
  output logic             halted,
  output logic             fault,
  output logic [15:0]      instr_count
);
  state_t           r_state, w_next;
  logic [BUS_W-1:0] r_instr;
  logic [15:0]      r_count;
  logic             w_wd_last, w_done;
  logic [3:0]       w_op;
  assign w_op = r_instr[15:12];
  assign w_done = r_state == S_EXEC && exec_done;
  if_watchdog #(.TIMEOUT(EXEC_TIMEOUT)) u_wd (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (r_state == S_DECODE),
    .i_en   (r_state == S_EXEC),
    .o_last (w_wd_last)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_instr <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IR_LOAD) r_instr <= bus_in;
      if (w_done) r_count <= r_count + 16'd1;
    end
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    w_next = S_PC_OUT;
      S_PC_OUT:  w_next = S_MEM_REQ;
      S_MEM_REQ: w_next = mem_ready ? S_IR_LOAD : S_MEM_REQ;
      S_IR_LOAD: w_next = S_DECODE;
      S_DECODE:  w_next = op_legal(w_op) ? S_EXEC : w_op == OP_HALT ? S_HALT : S_SKIP;
      S_EXEC:    w_next = exec_done ? S_PC_OUT : w_wd_last ? S_FAULT : S_EXEC;
      S_SKIP:    w_next = S_PC_OUT;
      S_HALT:    w_next = S_HALT;
      S_FAULT:   w_next = S_FAULT;
      default:   w_next = S_IDLE;
    endcase
  end
  // Strobes are masked while rst is high so a mid-fetch reset never leaks a bus command.
  always_comb begin
    pcOutEN   = !rst && r_state == S_PC_OUT;
    marLatch  = !rst && r_state == S_PC_OUT;
    memRead   = !rst && (r_state == S_MEM_REQ || r_state == S_IR_LOAD);
    mdrOutEN  = !rst && r_state == S_IR_LOAD;
    pcInc     = !rst && r_state == S_SKIP;
    illegal   = !rst && r_state == S_SKIP;
    halted    = !rst && r_state == S_HALT;
    fault     = !rst && r_state == S_FAULT;
    IF_active = rst || !(r_state inside {S_DECODE, S_EXEC, S_SKIP});
  end
  assign instruction = r_instr;
  assign instr_count = r_count;
endmodule

// File: tb/tb_if_fsm.sv
// tb_if_fsm: directed vectors feed an expectation queue; a negedge monitor pops and compares
module tb_if_fsm;
  logic        clk = 1'b0, rst = 1'b1, mem_ready = 1'b0, exec_done = 1'b0;
  logic [15:0] bus_in = '0;
  logic        pcOutEN, marLatch, memRead, mdrOutEN, IF_active, pcInc, illegal, halted, fault;
  logic [15:0] instruction, instr_count;
  logic [8:0]  obs;
  if_fsm #(.EXEC_TIMEOUT(32)) dut (
    .clk(clk), .rst(rst), .bus_in(bus_in), .mem_ready(mem_ready), .exec_done(exec_done),
    .pcOutEN(pcOutEN), .marLatch(marLatch), .memRead(memRead), .mdrOutEN(mdrOutEN),
    .IF_active(IF_active), .instruction(instruction), .pcInc(pcInc), .illegal(illegal),
    .halted(halted), .fault(fault), .instr_count(instr_count)
  );
  always #5 clk = ~clk;
  assign obs = {pcOutEN, marLatch, memRead, mdrOutEN, IF_active, pcInc, illegal, halted, fault};
  // {pcOutEN, marLatch, memRead, mdrOutEN, IF_active, pcInc, illegal, halted, fault}
  localparam logic [8:0] E_IDLE = 9'h010, E_PC = 9'h190, E_MR = 9'h050, E_IR = 9'h070;
  localparam logic [8:0] E_0 = 9'h000, E_SKIP = 9'h00C, E_HALT = 9'h012, E_FAULT = 9'h011;
  typedef struct {
    string       nm;
    logic [8:0]  s;
    logic [15:0] i;
    logic [15:0] c;
  } exp_t;
  exp_t q[$];
  exp_t m_e;
  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [15:0] a, input logic [15:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, a, x);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e = q.pop_front();
      chk({m_e.nm, ".strobes"}, {7'd0, obs}, {7'd0, m_e.s});
      chk({m_e.nm, ".instruction"}, instruction, m_e.i);
      chk({m_e.nm, ".instr_count"}, instr_count, m_e.c);
    end
  end
  task automatic cyc(input logic r, input logic mr, input logic ed, input logic [15:0] b,
                     input logic [8:0] s, input logic [15:0] i, input logic [15:0] c,
                     input string nm);
    rst = r; mem_ready = mr; exec_done = ed; bus_in = b;
    q.push_back('{nm, s, i, c});
    @(posedge clk); #1;
  endtask
  task automatic fetch(input logic [15:0] b, input logic [15:0] p, input logic [15:0] c,
                       input string nm);
    cyc(0, 1, 0, b, E_PC, p, c, {nm, ".pc"});
    cyc(0, 1, 0, b, E_MR, p, c, {nm, ".mr"});
    cyc(0, 1, 0, b, E_IR, p, c, {nm, ".ir"});
    cyc(0, 1, 0, b, E_0,  b, c, {nm, ".dec"});
  endtask
  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    @(posedge clk); #1;
    cyc(1, 1, 0, 16'h0, E_IDLE, 16'h0, 16'h0, "rst");
    cyc(0, 1, 0, 16'h0, E_IDLE, 16'h0, 16'h0, "idle");
    fetch(16'h1045, 16'h0, 16'h0, "t1");
    repeat (5) cyc(0, 1, 0, 16'h1045, E_0, 16'h1045, 16'h0, "t1.exec");
    cyc(0, 1, 1, 16'h1045, E_0, 16'h1045, 16'h0, "t1.done");
    // exec_done outside EXEC must not count; mem_ready low stretches MEM_REQ
    cyc(0, 1, 1, 16'hDEAD, E_PC, 16'h1045, 16'h1, "t2.pc");
    repeat (4) cyc(0, 0, 1, 16'hDEAD, E_MR, 16'h1045, 16'h1, "t2.wait");
    cyc(0, 1, 0, 16'hDEAD, E_MR, 16'h1045, 16'h1, "t2.mr");
    cyc(0, 1, 0, 16'h2345, E_IR, 16'h1045, 16'h1, "t2.ir");
    cyc(0, 1, 1, 16'hDEAD, E_0, 16'h2345, 16'h1, "t2.dec");
    cyc(0, 1, 1, 16'hDEAD, E_0, 16'h2345, 16'h1, "t2.exec");
    fetch(16'hA000, 16'h2345, 16'h2, "t3a");
    cyc(0, 1, 0, 16'hA000, E_SKIP, 16'hA000, 16'h2, "t3a.skip");
    fetch(16'h0123, 16'hA000, 16'h2, "t3b");
    cyc(0, 1, 0, 16'h0123, E_SKIP, 16'h0123, 16'h2, "t3b.skip");
    fetch(16'h9FFF, 16'h0123, 16'h2, "t3c");
    cyc(0, 1, 0, 16'h9FFF, E_SKIP, 16'h9FFF, 16'h2, "t3c.skip");
    fetch(16'h8FFF, 16'h9FFF, 16'h2, "t3d");
    cyc(0, 1, 1, 16'h8FFF, E_0, 16'h8FFF, 16'h2, "t3d.exec");
    fetch(16'h1111, 16'h8FFF, 16'h3, "t4");
    repeat (31) cyc(0, 1, 0, 16'h1111, E_0, 16'h1111, 16'h3, "t4.exec");
    cyc(0, 1, 1, 16'h1111, E_0, 16'h1111, 16'h3, "t4.last");
    cyc(0, 1, 0, 16'h1111, E_PC, 16'h1111, 16'h4, "t6.pc");
    cyc(0, 0, 0, 16'h1111, E_MR, 16'h1111, 16'h4, "t6.mr");
    cyc(1, 0, 0, 16'h1111, E_IDLE, 16'h1111, 16'h4, "t6.rst");
    force dut.r_count = 16'hFFFF;
    #1;
    release dut.r_count;
    cyc(0, 1, 0, 16'h0, E_IDLE, 16'h0, 16'hFFFF, "t6.idle");
    fetch(16'h3000, 16'h0, 16'hFFFF, "t6");
    cyc(0, 1, 1, 16'h3000, E_0, 16'h3000, 16'hFFFF, "t6.exec");
    fetch(16'h4321, 16'h3000, 16'h0, "t5");
    repeat (32) cyc(0, 1, 0, 16'h4321, E_0, 16'h4321, 16'h0, "t5.exec");
    repeat (3) cyc(0, 1, 1, 16'h4321, E_FAULT, 16'h4321, 16'h0, "t5.fault");
    cyc(1, 1, 0, 16'h4321, E_IDLE, 16'h4321, 16'h0, "t5.rst");
    cyc(0, 1, 0, 16'h0, E_IDLE, 16'h0, 16'h0, "t5.idle");
    fetch(16'hF000, 16'h0, 16'h0, "t7");
    repeat (100) cyc(0, 1, 1, 16'hF000, E_HALT, 16'hF000, 16'h0, "t7.halt");
    cyc(1, 1, 0, 16'hF000, E_IDLE, 16'hF000, 16'h0, "t7.rst");
    cyc(0, 1, 0, 16'h0, E_IDLE, 16'h0, 16'h0, "t7.idle");
    cyc(0, 1, 0, 16'h0, E_PC, 16'h0, 16'h0, "t7.pc");
    @(negedge clk); #1;
    chk("drain", 16'(q.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/if_fsm.md
IF_FSM -- requirements
Module: if_fsm

Interface
REQ-001 Parameter EXEC_TIMEOUT, default 32, max cycles in EXEC awaiting exec_done before fault.
REQ-002 clk  in  1  system clock; all state changes on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 bus_in  in  16  shared data bus; instruction word sampled in IR_LOAD.
REQ-005 mem_ready  in  1  memory read data valid on bus.
REQ-006 exec_done  in  1  OR of all execution-FSM done pulses.
REQ-007 pcOutEN  out  1  PC drives address bus.
REQ-008 marLatch  out  1  memory address register captures bus.
REQ-009 memRead  out  1  memory read request.
REQ-010 mdrOutEN  out  1  memory data register drives bus.
REQ-011 IF_active  out  1  fetch in progress; holds execution FSMs in their idle state.
REQ-012 instruction  out  16  instruction register, fed to all execution FSMs.
REQ-013 pcInc  out  1  PC increment, used only for illegal-opcode skip.
REQ-014 illegal  out  1  one-cycle pulse, illegal opcode decoded.
REQ-015 halted  out  1  HALT opcode executed; sticky until reset.
REQ-016 fault  out  1  exec_done timeout; sticky until reset.
REQ-017 instr_count  out  16  count of completed instructions.

Function
REQ-018 States SHALL be IDLE, PC_OUT, MEM_REQ, IR_LOAD, DECODE, EXEC, SKIP, HALT, FAULT; Moore outputs only.
REQ-019 IDLE: all strobes 0, IF_active=1; next PC_OUT after 1 cycle.
REQ-020 PC_OUT: pcOutEN=1, marLatch=1, IF_active=1; next MEM_REQ after 1 cycle.
REQ-021 MEM_REQ: memRead=1, IF_active=1; stay while mem_ready=0; next IR_LOAD the cycle after mem_ready=1 is sampled.
REQ-022 IR_LOAD: mdrOutEN=1, memRead=1, IF_active=1; instruction<=bus_in at end of cycle; next DECODE.
REQ-023 DECODE (IF_active=0 from here on): opcode=instruction[15:12]; 0001-1000 -> EXEC; 1111 -> HALT; 0000 and 1001-1110 -> SKIP.
REQ-024 EXEC: all strobes 0, IF_active=0; exec_done=1 -> PC_OUT and instr_count+1; else watchdog +1.
REQ-025 Watchdog SHALL clear on entry to EXEC; reaching EXEC_TIMEOUT without exec_done -> FAULT.
REQ-026 exec_done outside EXEC SHALL be ignored.
REQ-027 exec_done and timeout in the same cycle: exec_done wins.
REQ-028 SKIP: pcInc=1, illegal=1 for exactly 1 cycle; next PC_OUT; instr_count unchanged.
REQ-029 HALT: halted=1, IF_active=1, terminal until rst.
REQ-030 FAULT: fault=1, IF_active=1, terminal until rst.
REQ-031 instr_count wraps 16'hFFFF -> 16'h0000.
REQ-032 Minimum latency, PC_OUT to DECODE with mem_ready already 1 = 3 cycles.

Reset
REQ-033 rst=1 at posedge SHALL force IDLE, instruction=0, instr_count=0, watchdog=0, halted=0, fault=0; overrides every state, including mid-fetch and HALT/FAULT.
REQ-034 During and the cycle after reset, every output strobe SHALL be 0 except IF_active=1.

Structure
REQ-035 Shared package SHALL hold state encodings, opcode constants (legal range, HALT=4'b1111) and bus width 16.
REQ-036 Single flat module; watchdog counter MAY be sub-module if_watchdog.

Verification
REQ-037 mem_ready tied 1, bus_in=16'h1045, exec_done pulse 6 cycles after DECODE -> PC_OUT/MEM_REQ/IR_LOAD one cycle each, instruction=16'h1045, IF_active low from DECODE, instr_count=1.
REQ-038 mem_ready low 4 cycles -> MEM_REQ held 5 cycles with memRead=1; IR_LOAD follows, samples bus_in correctly.
REQ-039 bus_in=16'hA000 -> SKIP: pcInc and illegal high exactly 1 cycle, next PC_OUT, instr_count unchanged.
REQ-040 bus_in=16'hF000 -> halted=1, IF_active=1 held 100 cycles; rst pulse -> IDLE, halted=0.
REQ-041 Legal opcode, exec_done never asserted -> fault=1 after exactly 32 EXEC cycles; exec_done on cycle 32 -> no fault.
REQ-042 rst asserted in MEM_REQ -> next cycle IDLE, memRead=0, instruction=0; instr_count preset 16'hFFFF wraps to 0 on next completion.
